// File: rtl/fastbconvex_stream_pkg.sv
// fastbconvex_stream_pkg: shared RNS constants for the B u Ba -> q exact base
// converter (toy basis B={7,11}, Ba={13}, q={5}), residue types, beat mode
// type and the modular helpers used by the lane datapath.
package fastbconvex_stream_pkg;

  localparam int unsigned W           = 4;   // residue width
  localparam int unsigned B_LEN       = 2;   // number of B primes
  localparam int unsigned Q_LEN       = 1;   // number of q primes
  localparam int unsigned LANES_DEF   = 4;   // default coefficients per beat
  localparam int unsigned N_SLOTS_DEF = 4;   // default coefficients per polynomial
  localparam int unsigned PW          = 2 * W + 1;  // product width

  typedef logic [W-1:0] rns_residue_t;

  typedef enum logic {
    MODE_APPROX = 1'b0,
    MODE_EXACT  = 1'b1
  } conv_mode_e;

  localparam int unsigned B_BASIS  [B_LEN] = '{7, 11};
  localparam int unsigned Ba_BASIS [1]     = '{13};
  localparam int unsigned q_BASIS  [Q_LEN] = '{5};

  // (M/B_i)^-1 mod B_i, with M = prod(B)
  localparam int unsigned z_MOD_B   [B_LEN]        = '{2, 8};
  // (M/B_i) mod q_j and (M/B_i) mod Ba_0
  localparam int unsigned y_B_TO_q  [B_LEN][Q_LEN] = '{'{1}, '{2}};
  localparam int unsigned y_B_TO_Ba [B_LEN]        = '{11, 7};
  // M^-1 mod Ba_0 and M mod q_j
  localparam int unsigned binv_Ba_MOD_Ba           = 12;
  localparam int unsigned intb_MOD_q [Q_LEN]       = '{2};

  // Modulus of input slot s: B primes first, then the single Ba prime.
  function automatic int unsigned slot_modulus(int unsigned s);
    return (s < B_LEN) ? B_BASIS[s] : Ba_BASIS[0];
  endfunction

  // (a * c) mod m at full product width; c and m are basis constants < 2^W.
  function automatic rns_residue_t mod_mul(rns_residue_t a, int unsigned c,
                                           int unsigned m);
    logic [PW-1:0] p;
    p = PW'(a) * PW'(c);
    return W'(p % PW'(m));
  endfunction

endpackage

// File: rtl/fastbconvex_lane.sv
// fastbconvex_lane: single-coefficient 4-stage B u Ba -> q conversion datapath.
// All registers advance together on en; validity is tracked by the parent.
//   clk      clock
//   en       pipeline advance enable
//   exact_s2 mode of the beat currently held in the stage-2 registers
//   x        residues: B in slots [0..B_LEN-1], Ba in slot B_LEN
//   y        q residues, registered stage-4 result
module fastbconvex_lane
  import fastbconvex_stream_pkg::*;
(
  input  logic                     clk,
  input  logic                     en,
  input  logic                     exact_s2,
  input  logic [(B_LEN+1)*W-1:0]   x,
  output logic [Q_LEN*W-1:0]       y
);

  localparam int unsigned  BA   = Ba_BASIS[0];
  localparam rns_residue_t BA_R = W'(BA);
  localparam int unsigned  AW   = PW + $clog2(B_LEN) + 1;
  localparam int unsigned  SW   = 2 * W + 2;

  // Stage 1: t_i = x_i * z_i mod B_i
  rns_residue_t t1_d [B_LEN];
  rns_residue_t t1   [B_LEN];
  rns_residue_t xba1;

  always_comb begin
    for (int unsigned i = 0; i < B_LEN; i++) begin
      t1_d[i] = mod_mul(x[i*W +: W], z_MOD_B[i], B_BASIS[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      t1   <= t1_d;
      xba1 <= x[B_LEN*W +: W];
    end
  end

  // Stage 2: fast conversion into each q prime and into Ba
  rns_residue_t xq2_d [Q_LEN];
  rns_residue_t xq2   [Q_LEN];
  rns_residue_t xa2_d;
  rns_residue_t xa2;
  rns_residue_t xba2;

  always_comb begin
    logic [AW-1:0] acc;
    acc = '0;
    for (int unsigned j = 0; j < Q_LEN; j++) begin
      acc = '0;
      for (int unsigned i = 0; i < B_LEN; i++) begin
        acc = acc + AW'(t1[i]) * AW'(y_B_TO_q[i][j]);
      end
      xq2_d[j] = W'(acc % AW'(q_BASIS[j]));
    end
    acc = '0;
    for (int unsigned i = 0; i < B_LEN; i++) begin
      acc = acc + AW'(t1[i]) * AW'(y_B_TO_Ba[i]);
    end
    xa2_d = W'(acc % AW'(BA));
  end

  always_ff @(posedge clk) begin
    if (en) begin
      xq2  <= xq2_d;
      xa2  <= xa2_d;
      xba2 <= xba1;
    end
  end

  // Stage 3: centred gamma from the Ba discrepancy
  rns_residue_t     xb_r;
  logic [W:0]       diff_ba;
  rns_residue_t     temp3;
  rns_residue_t     g3;
  logic signed [W:0] gamma3_d;
  rns_residue_t     xq3 [Q_LEN];
  logic signed [W:0] gamma3;

  always_comb begin
    // x_Ba is reduced first so an out-of-range input still yields a residue
    xb_r     = xba2 % BA_R;
    diff_ba  = {1'b0, xa2} + {1'b0, BA_R} - {1'b0, xb_r};
    temp3    = W'(diff_ba % {1'b0, BA_R});
    g3       = mod_mul(temp3, binv_Ba_MOD_Ba, BA);
    gamma3_d = '0;
    if (exact_s2) begin
      if (32'(g3) > BA / 2) gamma3_d = $signed({1'b0, g3}) - $signed({1'b0, BA_R});
      else                  gamma3_d = $signed({1'b0, g3});
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      xq3    <= xq2;
      gamma3 <= gamma3_d;
    end
  end

  // Stage 4: y_j = (xq_j - gamma * (M mod q_j)) mod q_j, non-negative
  logic [Q_LEN*W-1:0] y_d;

  always_comb begin
    logic signed [SW-1:0] prod;
    logic signed [SW-1:0] diff;
    logic signed [SW-1:0] qs;
    logic signed [SW-1:0] r;
    prod = '0;
    diff = '0;
    qs   = '0;
    r    = '0;
    y_d  = '0;
    for (int unsigned j = 0; j < Q_LEN; j++) begin
      qs   = $signed(SW'(q_BASIS[j]));
      prod = $signed({{(SW-W-1){gamma3[W]}}, gamma3}) * $signed(SW'(intb_MOD_q[j]));
      diff = $signed(SW'(xq3[j])) - prod;
      r    = diff % qs;
      if (r < 0) r = r + qs;
      y_d[j*W +: W] = W'(r);
    end
  end

  always_ff @(posedge clk) begin
    if (en) y <= y_d;
  end

endmodule

// File: rtl/fastbconvex_stream.sv
// fastbconvex_stream: streaming B u Ba -> q base converter, LANES coefficients
// per beat, 4-stage pipeline with valid/ready backpressure, per-beat mode and
// polynomial-boundary tracking.
//   clk, reset     clock, asynchronous active-high reset
//   in_valid/ready input handshake; in_ready is the global stall enable
//   in_mode_exact  1 = gamma-corrected, 0 = fast conversion only
//   in_x           per-lane residues, LANES x (B_LEN+1) x W
//   out_valid/ready output handshake
//   out_y          per-lane q residues, LANES x Q_LEN x W
//   out_last       final beat of a polynomial
//   err_range      sticky: an accepted residue was >= its modulus
module fastbconvex_stream
  import fastbconvex_stream_pkg::*;
#(
  parameter int unsigned LANES   = LANES_DEF,
  parameter int unsigned N_SLOTS = N_SLOTS_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_mode_exact,
  input  logic [LANES*(B_LEN+1)*W-1:0]   in_x,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES*Q_LEN*W-1:0]       out_y,
  output logic                           out_last,
  output logic                           err_range
);

  localparam int unsigned N_BEATS = N_SLOTS / LANES;
  localparam int unsigned CW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

  logic          en;
  logic          v1, v2, v3, v4;
  conv_mode_e    m1, m2;
  logic [CW-1:0] beat_cnt;
  logic          bad_in;

  assign en        = !v4 || out_ready;
  assign in_ready  = en;
  assign out_valid = v4;
  assign out_last  = v4 && (beat_cnt == CW'(N_BEATS - 1));

  always_comb begin
    bad_in = 1'b0;
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned s = 0; s <= B_LEN; s++) begin
        if (32'(in_x[(l*(B_LEN+1)+s)*W +: W]) >= slot_modulus(s)) bad_in = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      v4        <= 1'b0;
      m1        <= MODE_APPROX;
      m2        <= MODE_APPROX;
      beat_cnt  <= '0;
      err_range <= 1'b0;
    end else begin
      if (en) begin
        v1 <= in_valid;
        v2 <= v1;
        v3 <= v2;
        v4 <= v3;
        m1 <= in_mode_exact ? MODE_EXACT : MODE_APPROX;
        m2 <= m1;
      end
      if (v4 && out_ready) begin
        beat_cnt <= (beat_cnt == CW'(N_BEATS - 1)) ? '0 : beat_cnt + 1'b1;
      end
      if (in_valid && en && bad_in) err_range <= 1'b1;
    end
  end

  // Mode only matters at the gamma stage, which reads the stage-2 beat.
  logic exact_s2;
  assign exact_s2 = (m2 == MODE_EXACT);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fastbconvex_lane u_lane (
      .clk      (clk),
      .en       (en),
      .exact_s2 (exact_s2),
      .x        (in_x[l*(B_LEN+1)*W +: (B_LEN+1)*W]),
      .y        (out_y[l*Q_LEN*W +: Q_LEN*W])
    );
  end

endmodule

// File: tb/tb_fastbconvex_stream.sv
// tb_fastbconvex_stream: scoreboard bench for fastbconvex_stream in the toy
// configuration (B={7,11}, Ba={13}, q={5}, LANES=1, N_SLOTS=4). Expected
// outputs come from a CRT-level reference model with derived constants.
module tb_fastbconvex_stream;

  localparam int BB0 = 7;
  localparam int BB1 = 11;
  localparam int BA  = 13;
  localparam int QQ  = 5;
  localparam int MB  = BB0 * BB1;
  localparam int NB  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_mode_exact = 1'b0;
  logic [11:0] in_x = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_y;
  logic        out_last;
  logic        err_range;

  fastbconvex_stream #(.LANES(1), .N_SLOTS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mode_exact (in_mode_exact),
    .in_x          (in_x),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_y         (out_y),
    .out_last      (out_last),
    .err_range     (err_range)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] y;
    logic       last;
    int         acc_cyc;
    bit         chk_lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_pushed = 0;
  int   rdy_mode = 0;
  bit   err_model = 1'b0;
  bit   prev_stall = 1'b0;
  logic [3:0] prev_y = '0;
  logic prev_last = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pmod(int a, int m);
    return ((a % m) + m) % m;
  endfunction

  function automatic int inv_mod(int a, int m);
    for (int k = 1; k < m; k++) if (pmod(a * k, m) == 1) return k;
    return 0;
  endfunction

  // CRT fast-conversion value v, then the unique centred correction c with
  // (v - c*M) == x_Ba (mod Ba); exact output is (v - c*M) mod q.
  function automatic logic [3:0] ref_y(logic [3:0] x0, logic [3:0] x1,
                                       logic [3:0] xb, bit exact);
    int bb [2];
    int xs [2];
    int v, mi, z;
    bb[0] = BB0; bb[1] = BB1;
    xs[0] = int'(x0); xs[1] = int'(x1);
    v = 0;
    for (int i = 0; i < 2; i++) begin
      mi = MB / bb[i];
      v  = v + pmod(xs[i] * inv_mod(mi % bb[i], bb[i]), bb[i]) * mi;
    end
    if (!exact) return 4'(v % QQ);
    for (int c = -(BA / 2); c <= BA / 2; c++) begin
      z = v - c * MB;
      if (pmod(z, BA) == int'(xb) % BA) return 4'(pmod(z, QQ));
    end
    return 4'd0;
  endfunction

  function automatic bit ref_bad(logic [11:0] x);
    return (int'(x[3:0]) >= BB0) || (int'(x[7:4]) >= BB1) || (int'(x[11:8]) >= BA);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, other = random
  initial begin
    int pk;
    logic [3:0] pat;
    pk  = 0;
    pat = 4'b1001;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) begin
        out_ready = 1'b1;
        pk = 0;
      end else if (rdy_mode == 1) begin
        out_ready = pat[pk];
        pk = (pk + 1) % 4;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        pk = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on each output transfer, checks stall
  // stability, in_ready and the sticky range flag.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        err_model  = 1'b0;
        prev_stall = 1'b0;
      end else begin
        chk("in_ready", int'(in_ready), int'(!out_valid || out_ready));
        chk("err_range", int'(err_range), int'(err_model));
        if (prev_stall) begin
          chk("stall_valid", int'(out_valid), 1);
          chk("stall_y", int'(out_y), int'(prev_y));
          chk("stall_last", int'(out_last), int'(prev_last));
        end
        if (!out_valid) chk("idle_last", int'(out_last), 0);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_out: got y=%0d with no beat expected (t=%0t)", out_y, $time);
          end else begin
            e = sb.pop_front();
            chk("out_y", int'(out_y), int'(e.y));
            chk("out_last", int'(out_last), int'(e.last));
            if (e.chk_lat) chk("latency", cyc - e.acc_cyc, 4);
          end
        end
        if (in_valid && in_ready && ref_bad(in_x)) err_model = 1'b1;
        prev_stall = out_valid && !out_ready;
        prev_y     = out_y;
        prev_last  = out_last;
      end
    end
  end

  // exp_y < 0 selects the reference model, otherwise a fixed expectation.
  task automatic send(input logic [3:0] x0, input logic [3:0] x1,
                      input logic [3:0] xb, input bit exact,
                      input int exp_y, input bit lat);
    bit   acc;
    exp_t e;
    @(posedge clk);
    #1;
    in_valid      = 1'b1;
    in_x          = {xb, x1, x0};
    in_mode_exact = exact;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0 for 100 cycles (t=%0t)", $time);
    end else begin
      e.y       = (exp_y < 0) ? ref_y(x0, x1, xb, exact) : 4'(exp_y);
      e.last    = ((n_pushed % NB) == NB - 1);
      e.acc_cyc = cyc;
      e.chk_lat = lat;
      sb.push_back(e);
      n_pushed++;
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_left", sb.size(), 0);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_err_range", int'(err_range), 0);
    chk("rst_out_last", int'(out_last), 0);
    reset = 1'b0;

    // 8 back-to-back x=76 beats, full throughput
    for (int i = 0; i < 8; i++) send(4'd6, 4'd10, 4'd11, 1'b1, 1, 1'b0);
    drain();

    // Same stream under a 1,0,0,1 ready pattern
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) send(4'd6, 4'd10, 4'd11, 1'b1, 1, 1'b0);
    drain();
    rdy_mode = 0;

    // Directed single beats with latency check
    send(4'd2, 4'd8, 4'd4, 1'b1, 0, 1'b1);
    drain();
    send(4'd2, 4'd8, 4'd4, 1'b0, 2, 1'b1);
    drain();
    send(4'd2, 4'd2, 4'd0, 1'b1, 1, 1'b1);
    drain();

    // Random in-range stream, mixed modes, random gaps and backpressure
    rdy_mode = 2;
    for (int i = 0; i < 80; i++) begin
      send(4'($urandom_range(0, BB0 - 1)), 4'($urandom_range(0, BB1 - 1)),
           4'($urandom_range(0, BA - 1)), 1'($urandom_range(0, 1)), -1, 1'b0);
      if ($urandom_range(0, 3) == 0) idle();
    end
    drain();
    rdy_mode = 0;

    // Out-of-range residue sets the sticky flag; data still converted
    send(4'd9, 4'd0, 4'd0, 1'b1, -1, 1'b0);
    send(4'd3, 4'd5, 4'd7, 1'b0, -1, 1'b0);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", int'(err_range), 1);

    // Mid-stream reset with 3 beats in flight and one presented
    for (int i = 0; i < 4; i++) send(4'd6, 4'd10, 4'd11, 1'b1, 1, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    chk("pre_reset_valid", int'(out_valid), 1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_err", int'(err_range), 0);
    chk("async_rst_last", int'(out_last), 0);
    n_pushed = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // First post-reset polynomial: out_last on the 4th output
    for (int i = 0; i < 4; i++) send(4'd2, 4'd8, 4'd4, 1'b1, 0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fastbconvex_stream.md
Name: fastbconvex_stream

Overview:
- Streaming, parametrised successor to the single-shot B∪Ba→q exact base converter.
- Accepts LANES coefficients per beat, with residues in B plus one Ba prime. Emits residues in q with gamma correction (exact mode) or without it (approx mode).
- Fully pipelined with valid/ready backpressure and automatic polynomial-boundary tracking.
- Sits between the mod-raise/mult stage and the q-basis NTT/rescale path of the keyswitch datapath.

Parameters:
- LANES, 4, coefficients processed per beat; must divide `N_SLOTS.
- B_LEN, `B_BASIS_LEN, number of B primes; Ba is fixed at exactly 1 prime.
- Q_LEN, `q_BASIS_LEN, number of output q primes.
- W, `RNS_PRIME_BITS, residue width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat this cycle
- in_mode_exact  in  1  1 = gamma-corrected, 0 = fast conversion only; sampled per beat
- in_x  in  LANES×(B_LEN+1)×W  per-lane residues; B in slots [0..B_LEN-1], Ba in slot B_LEN
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_y  out  LANES×Q_LEN×W  per-lane q residues
- out_last  out  1  final beat of a polynomial (beat N_SLOTS/LANES-1)
- err_range  out  1  sticky: some accepted input residue ≥ its modulus

Behaviour:
- Reset (asynchronous, active-high): all stage valids = 0, out_valid = 0, beat counter = 0, err_range = 0. Data registers are don't-care. Reset mid-stream discards all in-flight beats.
- Pipeline: 4 stages, latency 4 cycles from accept to out_valid when out_ready is held high. Throughput 1 beat/cycle.
  - S1: t_i = x_i·z_MOD_B[i] mod B_i.
  - S2: xq_j = Σ t_i·y_B_TO_q[i][j] mod q_j, and xa = Σ t_i·y_B_TO_Ba[i] mod Ba_0.
  - S3: temp = (xa − x_Ba) mod Ba_0, range [0, Ba_0).
    - g = temp·binv_Ba_MOD_Ba mod Ba_0.
    - gamma = g − Ba_0 if g > Ba_0/2, else g (signed, W+1 bits).
    - Forced to 0 when the beat's mode is approx.
    - xq carried forward.
  - S4: y_j = (xq_j − gamma·intb_MOD_q[j]) mod q_j, a true non-negative mod in [0, q_j).
  - Products are computed at 2W+1 signed bits; no truncation before reduction.
- Stall: global enable en = !s4_valid || out_ready. All stages advance only when en is high; in_ready = en.
  - A held stall keeps out_y, out_valid and out_last stable.
- Handshake: an input transfers when in_valid && in_ready; an output transfers when out_valid && out_ready.
  - Valid bubbles propagate. A stage whose valid is 0 never asserts out_valid.
- Beat counter: 0..N_SLOTS/LANES−1. It increments on each output transfer and wraps to 0 after the last beat. out_last = out_valid && (counter == N_SLOTS/LANES−1).
- Mode: carried per beat through the pipe, so mixed-mode streams are legal.
- err_range: set in the cycle after any accepted beat in which a residue is ≥ its modulus. It is cleared only by reset; the data still flows unmodified.
- Simultaneous input accept and output transfer while full: allowed, no bubble inserted.

Decomposition:
- Package fhe_consts (shared, existing) holds:
  - rns_residue_t
  - B_BASIS, Ba_BASIS, q_BASIS
  - z_MOD_B, y_B_TO_q, y_B_TO_Ba
  - binv_Ba_MOD_Ba, intb_MOD_q
- One sub-module, fastbconvex_lane: a single-coefficient 4-stage datapath taking en as input. The top instantiates LANES copies and owns the valid/mode/counter/stall control.

Test Plan (toy package: B={7,11}, Ba={13}, q={5}, LANES=1, N_SLOTS=4):
- x=30 → in_x=(2,8,4), exact → out_y=0 exactly 4 cycles after accept. The same beat in approx mode → out_y=2.
- in_x=(2,2,0), exact, exercising negative gamma (temp=1, g=12, gamma=−1) → out_y=1.
- 8 back-to-back beats, all x=76 → in_x=(6,10,11), exact, out_ready=1 → out_y=1 every cycle. out_last pulses on output beats 3 and 7.
- The same stream with out_ready toggled 1,0,0,1 → no loss or duplication. out_y stays stable while stalled; in_ready equals the stall enable.
- in_x=(9,0,0) → err_range=1 the following cycle and stays 1 until reset.
- Reset asserted mid-stream with 3 beats in flight → out_valid=0 and err_range=0 immediately, asynchronously. The first post-reset output has out_last aligned to the new count.
